// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: N requesters share one registered valid/ready channel,
// each granted for a burst of up to weight_i[p] beats.
module wrr_arbiter #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned N_PORTS      = 4,
   parameter int unsigned WEIGHT_WIDTH = 4,
   parameter int unsigned SRC_WIDTH    = $clog2(N_PORTS)
) (
   input  logic                                   aclk,
   input  logic                                   areset_n,
   input  logic [N_PORTS-1:0]                     prev_valid_i,
   input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]     prev_data_i,
   output logic [N_PORTS-1:0]                     prev_ready_o,
   input  logic [N_PORTS-1:0][WEIGHT_WIDTH-1:0]   weight_i,
   output logic                                   next_valid_o,
   output logic [DATA_WIDTH-1:0]                  next_data_o,
   output logic [SRC_WIDTH-1:0]                   next_src_o,
   input  logic                                   next_ready_i
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                  state;
   logic [SRC_WIDTH-1:0]    gnt;
   logic [SRC_WIDTH-1:0]    ptr;
   logic [WEIGHT_WIDTH-1:0] cnt;
   logic [WEIGHT_WIDTH-1:0] lim;

   logic                    acc;
   logic                    xfer;
   logic                    burst_end;
   logic                    found;
   logic [SRC_WIDTH-1:0]    pick;
   logic [SRC_WIDTH-1:0]    cand;
   logic [SRC_WIDTH-1:0]    gnt_nxt;
   logic [WEIGHT_WIDTH-1:0] cnt_inc;
   logic [WEIGHT_WIDTH-1:0] pick_lim;

   // Output register can take a beat when empty or being drained this cycle.
   assign acc       = !next_valid_o || next_ready_i;
   assign xfer      = (state == GRANT) && prev_valid_i[gnt] && acc;
   assign cnt_inc   = cnt + WEIGHT_WIDTH'(1);
   assign burst_end = (state == GRANT) && ((xfer && (cnt_inc == lim)) || !prev_valid_i[gnt]);
   assign gnt_nxt   = (gnt == SRC_WIDTH'(N_PORTS - 1)) ? '0 : gnt + SRC_WIDTH'(1);
   assign pick_lim  = (weight_i[pick] == '0) ? WEIGHT_WIDTH'(1) : weight_i[pick];

   // Round-robin search starting at ptr.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         cand = SRC_WIDTH'((32'(ptr) + i) % N_PORTS);
         if (!found && prev_valid_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      prev_ready_o = '0;
      if (state == GRANT) prev_ready_o[gnt] = acc;
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state        <= IDLE;
         gnt          <= '0;
         ptr          <= '0;
         cnt          <= '0;
         lim          <= WEIGHT_WIDTH'(1);
         next_valid_o <= 1'b0;
         next_data_o  <= '0;
         next_src_o   <= '0;
      end else begin
         if (xfer) begin
            next_data_o  <= prev_data_i[gnt];
            next_src_o   <= gnt;
            next_valid_o <= 1'b1;
         end else if (next_ready_i) begin
            next_valid_o <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (found) begin
                  gnt   <= pick;
                  lim   <= pick_lim;
                  cnt   <= '0;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (xfer) cnt <= cnt_inc;
               if (burst_end) begin
                  ptr   <= gnt_nxt;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Weighted round-robin arbiter that shares one valid/ready output channel among `N_PORTS` requesters. Each port gets a burst of up to `weight_i[p]` beats per grant. Grant rotation is round-robin, starting from the port after the last one granted. The block generalizes the two-input round-robin arbiter to N ports with per-port bandwidth weights. It drives a registered output stage, so downstream logic sees no combinational path from the inputs.

## Interface
- `DATA_WIDTH`, 16, payload width per beat
- `N_PORTS`, 4, number of requesters (≥2)
- `WEIGHT_WIDTH`, 4, width of each per-port weight
- `SRC_WIDTH`, `$clog2(N_PORTS)`, width of the source-index output (derived)

Ports:
- `aclk`  in  1  clock; all state updates on the rising edge
- `areset_n`  in  1  reset, asynchronous, active-low
- `prev_valid_i`  in  N_PORTS  per-port request/beat valid
- `prev_data_i`  in  N_PORTS×DATA_WIDTH  per-port payload
- `prev_ready_o`  out  N_PORTS  per-port accept; a beat transfers on port p when `prev_valid_i[p] & prev_ready_o[p]`
- `weight_i`  in  N_PORTS×WEIGHT_WIDTH  per-port burst weight; sampled when the grant is taken
- `next_valid_o`  out  1  output beat valid (registered)
- `next_data_o`  out  DATA_WIDTH  output payload (registered)
- `next_src_o`  out  SRC_WIDTH  index of the port that supplied the current output beat (registered)
- `next_ready_i`  in  1  downstream accept

## Operation
- **Two-state FSM: IDLE and GRANT.** Registers:
  - `gnt` (SRC_WIDTH): granted port
  - `ptr` (SRC_WIDTH): search start
  - `cnt` (WEIGHT_WIDTH): beats sent in the current burst
  - `lim` (WEIGHT_WIDTH): burst limit
- **IDLE.** Search ports `ptr, ptr+1, … mod N_PORTS` and pick the first with `prev_valid_i` high.
  - If one is found: `gnt`←p, `lim`←max(`weight_i[p]`,1), `cnt`←0, go to GRANT.
  - If none is found: stay in IDLE.
  - `prev_ready_o` is all zero in IDLE.
- **Output-stage accept.** `acc = !next_valid_o | next_ready_i`.
- **GRANT.** `prev_ready_o[gnt] = acc`; all other bits are 0.
  - On a transfer: `next_data_o`←`prev_data_i[gnt]`, `next_src_o`←`gnt`, `next_valid_o`←1, `cnt`←`cnt`+1.
  - If there is no transfer and `next_ready_i` is high, `next_valid_o`←0.
- **Burst end.** The grant is released and the FSM returns to IDLE with `ptr`←`gnt`+1 (mod N_PORTS) when either:
  - a transfer occurs and `cnt`+1 == `lim`, or
  - `prev_valid_i[gnt]` is low in GRANT (port went idle).
- **Weight 0** is treated as weight 1.
- **Backpressure.** Weight counting is by transferred beats only. A stalled cycle (`acc`=0) does not advance `cnt`.
- **Output register.** It holds `next_data_o` and `next_src_o` stable while `next_valid_o & !next_ready_i`. No beat is dropped or duplicated.
- **`ptr` wrap.** `ptr` wraps from N_PORTS-1 to 0.
- **Reset values** (on assertion of `areset_n` low, asynchronous, including mid-burst):
  - state = IDLE
  - `gnt`, `ptr`, `cnt` = 0; `lim` = 1
  - `next_valid_o` = 0, `next_data_o` = 0, `next_src_o` = 0, `prev_ready_o` = 0
  - A beat held in the output register is discarded.

## Timing
- **Arbitration:** 1 cycle. A port whose valid rises in IDLE at edge t is granted at edge t+1. Its first beat can transfer in the cycle after t+1, and appears on `next_valid_o` after the following edge.
- **Input-to-output latency:** 1 cycle from input transfer to output valid.
- **Throughput:** one beat per cycle within a burst. Every grant switch costs exactly one idle cycle.
- **Combinational path:** `prev_ready_o` depends combinationally on `next_ready_i`, `next_valid_o` and state only. There is no path from `prev_valid_i` to `prev_ready_o`.
- **`weight_i` sampling:** changes to `weight_i` during a burst take effect at the next grant of that port.

## Test plan
- **Weighted rotation.** Weights {2,1,1,1}, all four ports continuously valid with data 16'hA000+p, `next_ready_i`=1 → `next_src_o` sequence 0,0,1,2,3,0,0,1… with one bubble between bursts.
- **Backpressure.** Port 1 only, weight 4, `next_ready_i` low for 3 cycles mid-burst → `next_data_o`/`next_src_o` stable and `prev_ready_o[1]`=0 during the stall; exactly 4 beats total delivered in order.
- **Early release.** Port 2 weight 8 supplies 3 beats then drops valid; port 3 waiting → grant moves to port 3 after 3 beats, and `next_src_o` shows 2,2,2,3.
- **Weight zero and wrap.** Port 3 weight 0, ports 3 and 0 valid, `ptr`=3 → port 3 sends 1 beat, then port 0 is granted (`ptr` wraps to 0).
- **Reset mid-burst.** Assert `areset_n` low while GRANT and `next_valid_o`=1 → all outputs 0 immediately, without waiting for a clock edge. After release, the first grant goes to the lowest-index valid port.
- **Single requester.** Only port 0 valid, weight 1, 4 beats → source 0 four times, with an IDLE bubble between each beat.
